// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM driver for an RGB LED; colours arrive over valid/ready and are applied at period boundaries.
// Optional macro RGB_PWM_ACTIVE_LOW_EN inverts pwm_r/g/b for common-anode LEDs.
module rgb_pwm_driver #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b,
  output logic       frame_start
);

`ifdef RGB_PWM_ACTIVE_LOW_EN
  localparam logic PWM_OFF = 1'b1;
`else
  localparam logic PWM_OFF = 1'b0;
`endif

  localparam logic [15:0] PSC_LAST = 16'(PRESCALE - 1);
  localparam logic [7:0]  CNT_LAST = 8'd254;

  logic [15:0] r_psc;
  logic [7:0]  r_cnt;
  logic [23:0] r_pending;
  logic [23:0] r_active;
  logic        r_pending_full;
  logic        r_enable_d;

  logic        w_tick;
  logic        w_boundary;
  logic        w_capture;
  logic        w_apply;
  logic [2:0]  w_on;

  // Timing strobes, handshake decode and per-channel compare against the live colour.
  always_comb begin
    w_tick     = enable && (r_psc == PSC_LAST);
    w_boundary = w_tick && (r_cnt == CNT_LAST);
    w_capture  = in_valid && !r_pending_full;
    // While disabled there is no period to protect, so the pending colour goes straight through.
    w_apply    = r_pending_full && (w_boundary || !enable);
    w_on       = {enable && (r_cnt < r_active[23:16]),
                  enable && (r_cnt < r_active[15:8]),
                  enable && (r_cnt < r_active[7:0])};
  end

  assign in_ready = !r_pending_full;

  // Prescaler and 0..254 period counter, both held at zero while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psc <= 16'd0;
      r_cnt <= 8'd0;
    end else if (!enable) begin
      r_psc <= 16'd0;
      r_cnt <= 8'd0;
    end else if (w_tick) begin
      r_psc <= 16'd0;
      r_cnt <= (r_cnt == CNT_LAST) ? 8'd0 : r_cnt + 8'd1;
    end else begin
      r_psc <= r_psc + 16'd1;
    end
  end

  // Double buffer: capture into pending, promote to active at the boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending      <= 24'd0;
      r_active       <= 24'd0;
      r_pending_full <= 1'b0;
    end else if (w_apply) begin
      r_active       <= r_pending;
      r_pending_full <= 1'b0;
    end else if (w_capture) begin
      r_pending      <= {red, green, blue};
      r_pending_full <= 1'b1;
    end else begin
      r_pending_full <= r_pending_full;
    end
  end

  // Registered PWM outputs and period-start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_r       <= PWM_OFF;
      pwm_g       <= PWM_OFF;
      pwm_b       <= PWM_OFF;
      frame_start <= 1'b0;
      r_enable_d  <= 1'b0;
    end else begin
      pwm_r       <= w_on[2] ^ PWM_OFF;
      pwm_g       <= w_on[1] ^ PWM_OFF;
      pwm_b       <= w_on[0] ^ PWM_OFF;
      frame_start <= w_boundary || (enable && !r_enable_d);
      r_enable_d  <= enable;
    end
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Scoreboard bench for rgb_pwm_driver: stimulus pushes expected per-period high counts,
// monitors close a window at each frame_start and compare.
module tb_rgb_pwm_driver;

`ifdef RGB_PWM_ACTIVE_LOW_EN
  localparam bit ON = 1'b0;
`else
  localparam bit ON = 1'b1;
`endif

  typedef struct {
    int win;
    int len;
    int hr;
    int hg;
    int hb;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1_n, en1, v1, rdy1, pr1, pg1, pb1, fs1;
  logic [7:0] r1, g1, b1;
  logic       rst4_n, en4, v4, rdy4, pr4, pg4, pb4, fs4;
  logic [7:0] r4, g4, b4;

  exp_t sb1[$];
  exp_t sb4[$];
  int   win1 = 0;
  int   win4 = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  rgb_pwm_driver #(.PRESCALE(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .enable(en1), .in_valid(v1), .in_ready(rdy1),
    .red(r1), .green(g1), .blue(b1),
    .pwm_r(pr1), .pwm_g(pg1), .pwm_b(pb1), .frame_start(fs1)
  );

  rgb_pwm_driver #(.PRESCALE(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .enable(en4), .in_valid(v4), .in_ready(rdy4),
    .red(r4), .green(g4), .blue(b4),
    .pwm_r(pr4), .pwm_g(pg4), .pwm_b(pb4), .frame_start(fs4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic push1(input int w, input int len, input int hr, input int hg, input int hb);
    exp_t e;
    e.win = w; e.len = len; e.hr = hr; e.hg = hg; e.hb = hb;
    sb1.push_back(e);
  endtask

  task automatic push4(input int w, input int len, input int hr, input int hg, input int hb);
    exp_t e;
    e.win = w; e.len = len; e.hr = hr; e.hg = hg; e.hb = hb;
    sb4.push_back(e);
  endtask

  // Monitor for the PRESCALE=1 instance: a window runs from the clock after one frame_start to the next frame_start.
  initial begin : mon1
    int len, hr, hg, hb;
    bit fs_d;
    exp_t e;
    len = 0; hr = 0; hg = 0; hb = 0; fs_d = 1'b0;
    forever begin
      @(negedge clk);
      if (rst1_n !== 1'b1) begin
        len = 0; hr = 0; hg = 0; hb = 0; fs_d = 1'b0;
      end else begin
        if (fs_d) begin
          while (sb1.size() != 0 && sb1[0].win <= win1) begin
            e = sb1.pop_front();
            if (e.win != win1) chk("dut1 window order", win1, e.win);
            else begin
              chk("dut1 period length", len, e.len);
              chk("dut1 red high clocks", hr, e.hr);
              chk("dut1 green high clocks", hg, e.hg);
              chk("dut1 blue high clocks", hb, e.hb);
            end
          end
          win1++;
          len = 0; hr = 0; hg = 0; hb = 0;
        end
        len++;
        hr += (pr1 === ON) ? 1 : 0;
        hg += (pg1 === ON) ? 1 : 0;
        hb += (pb1 === ON) ? 1 : 0;
        fs_d = (fs1 === 1'b1);
      end
    end
  end

  // Monitor for the PRESCALE=4 instance, same windowing.
  initial begin : mon4
    int len, hr, hg, hb;
    bit fs_d;
    exp_t e;
    len = 0; hr = 0; hg = 0; hb = 0; fs_d = 1'b0;
    forever begin
      @(negedge clk);
      if (rst4_n !== 1'b1) begin
        len = 0; hr = 0; hg = 0; hb = 0; fs_d = 1'b0;
      end else begin
        if (fs_d) begin
          while (sb4.size() != 0 && sb4[0].win <= win4) begin
            e = sb4.pop_front();
            if (e.win != win4) chk("dut4 window order", win4, e.win);
            else begin
              chk("dut4 period length", len, e.len);
              chk("dut4 red high clocks", hr, e.hr);
              chk("dut4 green high clocks", hg, e.hg);
              chk("dut4 blue high clocks", hb, e.hb);
            end
          end
          win4++;
          len = 0; hr = 0; hg = 0; hb = 0;
        end
        len++;
        hr += (pr4 === ON) ? 1 : 0;
        hg += (pg4 === ON) ? 1 : 0;
        hb += (pb4 === ON) ? 1 : 0;
        fs_d = (fs4 === 1'b1);
      end
    end
  end

  // Called on a falling edge; returns on the falling edge after the capture edge.
  task automatic send(input bit which, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b, output int waits);
    waits = 0;
    if (which) begin v4 = 1'b1; r4 = r; g4 = g; b4 = b; end
    else begin v1 = 1'b1; r1 = r; g1 = g; b1 = b; end
    while (((which ? rdy4 : rdy1) !== 1'b1) && waits < 2000) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 2000) fail_to("send handshake");
    @(negedge clk);
    if (which) v4 = 1'b0;
    else v1 = 1'b0;
  endtask

  task automatic wait_fs(input bit which);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((which ? fs4 : fs1) !== 1'b1) && n < 2000);
    if ((which ? fs4 : fs1) !== 1'b1) fail_to("wait frame_start");
  endtask

  task automatic run1();
    int n, base;
    @(negedge clk);
    send(1'b0, 8'd255, 8'd128, 8'd0, n);
    chk("dut1 in_ready low after capture", rdy1, 1'b0);
    n = 0;
    while (rdy1 !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("dut1 in_ready stall to first boundary", n, 253);
    chk("dut1 frame_start at first boundary", fs1, 1'b1);
    base = win1;
    push1(base,     254,   0,   0,  0);
    push1(base + 1, 255, 255, 128,  0);
    push1(base + 2, 255,  10,  20, 30);
    push1(base + 3, 255,  40,  50, 60);
    send(1'b0, 8'd10, 8'd20, 8'd30, n);
    chk("dut1 first back-to-back stall", n, 0);
    send(1'b0, 8'd40, 8'd50, 8'd60, n);
    chk("dut1 second back-to-back stall", n, 254);
    wait_fs(1'b0);
    wait_fs(1'b0);
    base = win1;
    push1(base + 1, 106, 41, 51, 61);
    push1(base + 2, 254,  6,  6,  6);
    push1(base + 3, 255,  7,  7,  7);
    repeat (100) @(negedge clk);
    en1 = 1'b0;
    @(negedge clk);
    chk("dut1 outputs off after disable", {pr1, pg1, pb1}, {3{~ON}});
    send(1'b0, 8'd7, 8'd7, 8'd7, n);
    chk("dut1 in_ready low after disabled capture", rdy1, 1'b0);
    @(negedge clk);
    chk("dut1 in_ready back while disabled", rdy1, 1'b1);
    repeat (2) @(negedge clk);
    en1 = 1'b1;
    @(negedge clk);
    chk("dut1 frame_start after enable rise", fs1, 1'b1);
    n = 0;
    while (pr1 === ON && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("dut1 red pulse width after enable", n, 7);
    wait_fs(1'b0);
    wait_fs(1'b0);
    send(1'b0, 8'd200, 8'd150, 8'd250, n);
    wait_fs(1'b0);
    send(1'b0, 8'd9, 8'd9, 8'd9, n);
    repeat (99) @(negedge clk);
    chk("dut1 outputs on before reset", {pr1, pg1, pb1}, {3{ON}});
    #2 rst1_n = 1'b0;
    #1;
    chk("dut1 outputs off in async reset", {pr1, pg1, pb1}, {3{~ON}});
    chk("dut1 in_ready during reset", rdy1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1 rst1_n = 1'b1;
    wait_fs(1'b0);
    base = win1;
    push1(base + 1, 254, 0, 0, 0);
    push1(base + 2, 255, 0, 0, 0);
    wait_fs(1'b0);
    wait_fs(1'b0);
    @(negedge clk);
  endtask

  task automatic run4();
    int n, base;
    @(negedge clk);
    send(1'b1, 8'd1, 8'd254, 8'd255, n);
    wait_fs(1'b1);
    base = win4;
    push4(base,     1019, 0,    0,    0);
    push4(base + 1, 1020, 4, 1016, 1020);
    push4(base + 2, 1020, 4, 1016, 1020);
    wait_fs(1'b1);
    wait_fs(1'b1);
    @(negedge clk);
  endtask

  initial begin
    rst1_n = 1'b0; en1 = 1'b1; v1 = 1'b0; r1 = 8'd0; g1 = 8'd0; b1 = 8'd0;
    rst4_n = 1'b0; en4 = 1'b1; v4 = 1'b0; r4 = 8'd0; g4 = 8'd0; b4 = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset pwm outputs", {pr1, pg1, pb1}, {3{~ON}});
    chk("reset frame_start", fs1, 1'b0);
    chk("reset in_ready", rdy1, 1'b1);
    chk("reset pwm outputs dut4", {pr4, pg4, pb4}, {3{~ON}});
    #1;
    rst1_n = 1'b1;
    rst4_n = 1'b1;
    fork
      run1();
      run4();
    join
    #1;
    chk("dut1 scoreboard drained", sb1.size(), 0);
    chk("dut4 scoreboard drained", sb4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
- Downstream of the HSL-to-RGB converter.
- Accepts 8-bit Red/Green/Blue codes through a valid/ready handshake.
- Drives three PWM outputs for an RGB LED on the demonstration board.
- New colours are double-buffered and applied only at a PWM period boundary, so the LED never shows a torn colour mid-period.

Parameters:
- PRESCALE, 4, clock cycles per PWM count step; legal range 1 to 65535. PWM period = 255*PRESCALE clocks.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  PWM run enable
- in_valid  input  1  red/green/blue valid
- in_ready  output  1  pending buffer empty; = !pending_full
- red  input  8  red duty code, 0 to 255
- green  input  8  green duty code
- blue  input  8  blue duty code
- pwm_r  output  1  red PWM
- pwm_g  output  1  green PWM
- pwm_b  output  1  blue PWM
- frame_start  output  1  one-clock pulse at the start of each PWM period

Behaviour:
- One clock domain. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - prescaler, pwm_cnt, pending and active registers all 0; pending_full=0.
  - pwm_r/g/b=0, frame_start=0.
  - in_ready reads 1 during reset, but no capture occurs while rst_n=0.
- Prescaler:
  - psc counts 0..PRESCALE-1 while enable=1.
  - tick = enable && psc==PRESCALE-1.
  - PRESCALE=1 gives tick every enabled clock.
- PWM counter:
  - pwm_cnt 0..254; increments on tick; wraps 254->0.
  - boundary = tick && pwm_cnt==254.
- Handshake:
  - Capture {red,green,blue} into pending when in_valid && in_ready; set pending_full.
  - Producer must hold data stable while in_valid=1 && in_ready=0.
- Apply:
  - On boundary with pending_full=1: active<=pending, pending_full<=0.
  - A capture in the same clock as boundary while pending is empty goes to pending only. It applies at the next boundary.
  - pending_full cannot be set and cleared in the same clock, because in_ready=0 whenever it is set.
- Output:
  - Each clock, registered: pwm_x <= enable && (pwm_cnt < active_x).
  - Latency is 1 clock from the counter/active state.
  - Duty = active_x/255 of the period.
  - Code 0: constantly low. Code 255: constantly high, no glitch at wrap.
- enable=0:
  - psc and pwm_cnt synchronously forced to 0; outputs low next clock.
  - Handshake continues. Pending transfers to active on every clock, so in_ready returns to 1 one clock after a capture.
- frame_start:
  - Registered pulse: frame_start <= boundary || (enable rising edge).
  - With enable=0 it stays low.
  - First period after enable rises: pulse on the clock after the edge.
- Reset mid-period: outputs drop at once. Any pending colour is lost. Operation restarts from count 0 with active=0.

Optional Feature:
- Macro RGB_PWM_ACTIVE_LOW_EN: for common-anode LEDs.
- With the macro defined:
  - pwm_r/g/b are inverted at the output register.
  - Reset value is 1; enable=0 drives 1; code 0 gives constant 1.
  - frame_start and the handshake are unchanged.
- Without it: active-high as described above.

Test Plan:
- PRESCALE=1, enable=1 from reset; send (255,128,0) at clock 2.
  - in_ready=0 until the first boundary (clock 255), then returns to 1.
  - Over the next 255 clocks: pwm_r high 255 clocks, pwm_g high 128 clocks, pwm_b high 0 clocks.
  - frame_start pulses once per 255 clocks.
- Back-to-back sends of (10,20,30) then (40,50,60), PRESCALE=1.
  - Second send stalls with in_ready=0 until the boundary.
  - Next period shows 10/20/30 high clocks; the period after shows 40/50/60.
- PRESCALE=4, active=(1,254,255).
  - Per 1020-clock period: pwm_r high exactly 4 clocks, pwm_g 1016, pwm_b 1020 with no low clock across wraps.
- Drop enable mid-period.
  - All outputs 0 one clock later.
  - A send of (7,7,7) is applied within 2 clocks and in_ready returns to 1.
  - Raise enable: frame_start pulses next clock; 7-clock high pulses follow (PRESCALE=1).
- Assert rst_n=0 asynchronously at pwm_cnt=100 with a colour pending.
  - Outputs 0 immediately, no clock needed.
  - After release, with enable=1 and no new send, outputs stay 0 for a full period (pending discarded).
- With RGB_PWM_ACTIVE_LOW_EN defined, repeat the first scenario.
  - pwm_r low 255 clocks, pwm_g low 128 clocks, pwm_b constant 1; reset value 1.
